// File: rtl/s1_fetch_pkg.sv
// rtl/s1_fetch_pkg.sv - shared constants and helpers for the stage-1 fetch slice
// Purpose: RV32I opcode constants, fetch reset/bubble defaults, memory address
//          widths, region-decode bit and J/B immediate decode helpers.
// Ports:   none (package).
package s1_fetch_pkg;

  typedef logic [6:0] opcode_t;

  localparam opcode_t OPC_LUI      = 7'b0110111;
  localparam opcode_t OPC_AUIPC    = 7'b0010111;
  localparam opcode_t OPC_JAL      = 7'b1101111;
  localparam opcode_t OPC_JALR     = 7'b1100111;
  localparam opcode_t OPC_BRANCH   = 7'b1100011;
  localparam opcode_t OPC_LOAD     = 7'b0000011;
  localparam opcode_t OPC_STORE    = 7'b0100011;
  localparam opcode_t OPC_OP_IMM   = 7'b0010011;
  localparam opcode_t OPC_OP       = 7'b0110011;
  localparam opcode_t OPC_MISC_MEM = 7'b0001111;
  localparam opcode_t OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] DEF_RESET_PC  = 32'h4000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

  localparam int DEF_BIOS_AW = 12;
  localparam int DEF_IMEM_AW = 14;

  // pc[30] set means the fetch address lives in the BIOS, clear means IMEM.
  localparam int REGION_BIT = 30;

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/s1_fetch_if.sv
// rtl/s1_fetch_if.sv - stage-1 fetch bus bundle (control, memory ports, S2 presentation)
// Purpose: groups the fetch control inputs, the BIOS/IMEM read ports and the
//          stage-2 presentation signals.
// Modports: master = fetch stage (drives addresses and S2 outputs),
//           slave  = environment (drives control and memory read data).
interface s1_fetch_if
  import s1_fetch_pkg::*;
#(
  parameter int BIOS_AW = DEF_BIOS_AW,
  parameter int IMEM_AW = DEF_IMEM_AW
) ();

  logic               stall;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic [BIOS_AW-1:0] bios_addr;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        bios_dout;
  logic [31:0]        imem_dout;
  logic [31:0]        pc_s2;
  logic [31:0]        instruction_s2;
  logic               valid_s2;
  logic               predicted_s2;

  modport master (
    input  stall, redirect_valid, redirect_pc, bios_dout, imem_dout,
    output bios_addr, imem_addr, pc_s2, instruction_s2, valid_s2, predicted_s2
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, bios_dout, imem_dout,
    input  bios_addr, imem_addr, pc_s2, instruction_s2, valid_s2, predicted_s2
  );

endinterface

// File: rtl/s1_next_pc.sv
// rtl/s1_next_pc.sv - combinational next-fetch-PC priority mux
// Purpose: picks pc_next from boot, redirect, stall, static prediction
//          (S1_BRANCH_PREDICT_EN only) and sequential pc+4.
// Ports:   i_boot, i_redirect_valid, i_redirect_pc, i_stall, i_pc in;
//          i_valid_s2, i_instruction_s2 in and o_pred_hit out with the macro;
//          o_pc_next out.
// Config:  S1_BRANCH_PREDICT_EN enables the static backward-branch/JAL predictor.
module s1_next_pc
  import s1_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        i_boot,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_stall,
  input  logic [31:0] i_pc,
`ifdef S1_BRANCH_PREDICT_EN
  input  logic        i_valid_s2,
  input  logic [31:0] i_instruction_s2,
  output logic        o_pred_hit,
`endif
  output logic [31:0] o_pc_next
);

  // Redirect targets are forced word-aligned; the low bits are dropped.
  logic w_unused_low;
  assign w_unused_low = ^i_redirect_pc[1:0];

`ifdef S1_BRANCH_PREDICT_EN
  logic        w_is_jal;
  logic        w_is_bwd_branch;
  logic [31:0] w_imm;
  logic [31:0] w_pred_target;

  assign w_is_jal        = (i_instruction_s2[6:0] == OPC_JAL);
  // B-type imm[12] is instr[31]; set means a backward branch, predicted taken.
  assign w_is_bwd_branch = (i_instruction_s2[6:0] == OPC_BRANCH) && i_instruction_s2[31];
  assign w_imm           = w_is_jal ? imm_j(i_instruction_s2) : imm_b(i_instruction_s2);
  assign w_pred_target   = i_pc + w_imm;
  assign o_pred_hit      = i_valid_s2 && !i_stall && !i_redirect_valid &&
                           (w_is_jal || w_is_bwd_branch);
`endif

  always_comb begin
    o_pc_next = i_pc + 32'd4;
    if (i_boot) begin
      o_pc_next = RESET_PC;
    end else if (i_redirect_valid) begin
      o_pc_next = {i_redirect_pc[31:2], 2'b00};
    end else if (i_stall) begin
      // Re-read the same word so the synchronous memory output stays put.
      o_pc_next = i_pc;
`ifdef S1_BRANCH_PREDICT_EN
    end else if (o_pred_hit) begin
      o_pc_next = w_pred_target;
`endif
    end
  end

endmodule

// File: rtl/s1_fetch.sv
// rtl/s1_fetch.sv - stage-1 instruction fetch for the 3-stage RV32I pipeline
// Purpose: holds the fetch PC, drives BIOS/IMEM word addresses, selects the
//          returned word and presents it to stage 2 with boot, stall and
//          redirect-kill handling.
// Ports:   clk, rst (async, active-high); bus (s1_fetch_if.master):
//          stall, redirect_valid, redirect_pc, bios_dout, imem_dout in;
//          bios_addr, imem_addr, pc_s2, instruction_s2, valid_s2, predicted_s2 out.
// Config:  S1_BRANCH_PREDICT_EN enables the static predictor; otherwise
//          predicted_s2 is tied low.
module s1_fetch
  import s1_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR,
  parameter int          BIOS_AW   = DEF_BIOS_AW,
  parameter int          IMEM_AW   = DEF_IMEM_AW
) (
  input  logic         clk,
  input  logic         rst,
  s1_fetch_if.master   bus
);

  logic [31:0] r_pc;
  logic        r_valid;
  logic        r_boot;

  logic [31:0] w_pc_next;
  logic        w_advance;
  logic        w_valid_s2;
  logic [31:0] w_word;
  logic [31:0] w_instruction_s2;

`ifdef S1_BRANCH_PREDICT_EN
  logic w_pred_hit;
  logic r_pred;
`endif

  s1_next_pc #(
    .RESET_PC (RESET_PC)
  ) u_next_pc (
    .i_boot           (r_boot),
    .i_redirect_valid (bus.redirect_valid),
    .i_redirect_pc    (bus.redirect_pc),
    .i_stall          (bus.stall),
    .i_pc             (r_pc),
`ifdef S1_BRANCH_PREDICT_EN
    .i_valid_s2       (w_valid_s2),
    .i_instruction_s2 (w_instruction_s2),
    .o_pred_hit       (w_pred_hit),
`endif
    .o_pc_next        (w_pc_next)
  );

  assign bus.bios_addr = w_pc_next[BIOS_AW+1:2];
  assign bus.imem_addr = w_pc_next[IMEM_AW+1:2];

  // A new word lands next cycle unless the stage is genuinely held by stall.
  assign w_advance = r_boot | bus.redirect_valid | ~bus.stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
      r_boot  <= 1'b1;
    end else begin
      r_pc   <= w_pc_next;
      r_boot <= 1'b0;
      if (w_advance) begin
        r_valid <= 1'b1;
      end
    end
  end

`ifdef S1_BRANCH_PREDICT_EN
  // Flag travels with the predicted target and holds with it under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pred <= 1'b0;
    end else if (w_advance) begin
      r_pred <= w_pred_hit;
    end
  end
`endif

  assign w_word           = r_pc[REGION_BIT] ? bus.bios_dout : bus.imem_dout;
  assign w_valid_s2       = r_valid & ~bus.redirect_valid & ~rst;
  assign w_instruction_s2 = w_valid_s2 ? w_word : NOP_INSTR;

  assign bus.pc_s2          = rst ? RESET_PC : r_pc;
  assign bus.valid_s2       = w_valid_s2;
  assign bus.instruction_s2 = w_instruction_s2;
`ifdef S1_BRANCH_PREDICT_EN
  assign bus.predicted_s2   = r_pred & w_valid_s2;
`else
  assign bus.predicted_s2   = 1'b0;
`endif

endmodule
